// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: grant selects, FSM states
// and the hard-wired zero register index.
package regfile_write_arbiter_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WB   = 2'd1,
      GNT_MD   = 2'd2,
      GNT_DBG  = 2'd3
   } gnt_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request/ack bundle between the writers (WB, MD, DBG, decode) and the arbiter,
// plus the register-file write port the arbiter drives.
interface regfile_write_arbiter_if;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        md_issue;
   logic [4:0]  md_issue_rd;
   logic        md_req;
   logic [4:0]  md_addr;
   logic [31:0] md_data;
   logic        md_ack;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        dbg_ack;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        stall;
   logic        pipe_hold;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   modport master (
      output wb_we, wb_addr, wb_data, md_issue, md_issue_rd, md_req, md_addr, md_data,
             dbg_req, dbg_addr, dbg_data, id_rs, id_rt,
      input  md_ack, dbg_ack, stall, pipe_hold, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  wb_we, wb_addr, wb_data, md_issue, md_issue_rd, md_req, md_addr, md_data,
             dbg_req, dbg_addr, dbg_data, id_rs, id_rt,
      output md_ack, dbg_ack, stall, pipe_hold, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-destination mask for in-flight MD results with two decode-stage
// hazard lookups. Register 0 can never become pending.
module regfile_scoreboard
   import regfile_write_arbiter_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       set_en_i,
   input  logic [4:0] set_idx_i,
   input  logic       clr_en_i,
   input  logic [4:0] clr_idx_i,
   input  logic [4:0] rs_i,
   input  logic [4:0] rt_i,
   output logic       stall_o
);

   logic [31:0] pending_q, pending_d;

   // Set is applied after clear so a same-cycle issue to a retiring register wins.
   always_comb begin
      pending_d = pending_q;
      if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
      if (set_en_i && (set_idx_i != REG_ZERO)) pending_d[set_idx_i] = 1'b1;
      pending_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pending_q <= '0;
      else         pending_q <= pending_d;
   end

   // Reads the registered mask, so a committing MD write still stalls decode.
   assign stall_o = ((rs_i != REG_ZERO) && pending_q[rs_i]) ||
                    ((rt_i != REG_ZERO) && pending_q[rt_i]);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port arbitration between WB, MD and DBG, with an MD starvation
// guard that freezes the pipeline until MD gets its slot.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic                    clock_in,
   input  logic                    reset,
   regfile_write_arbiter_if.slave  bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   gnt_e             gnt;
   logic [4:0]       waddr;
   logic [31:0]      wdata;
   logic             md_gnt;
   logic             md_refused;

   // WB is only eligible in RUN; requests are ignored entirely while in reset.
   always_comb begin
      gnt = GNT_NONE;
      if (reset) begin
         if ((state_q == RUN) && bus.wb_we) gnt = GNT_WB;
         else if (bus.md_req)               gnt = GNT_MD;
         else if (bus.dbg_req)              gnt = GNT_DBG;
      end
   end

   always_comb begin
      waddr = REG_ZERO;
      wdata = '0;
      unique case (gnt)
         GNT_WB:  begin waddr = bus.wb_addr;  wdata = bus.wb_data;  end
         GNT_MD:  begin waddr = bus.md_addr;  wdata = bus.md_data;  end
         GNT_DBG: begin waddr = bus.dbg_addr; wdata = bus.dbg_data; end
         default: ;
      endcase
   end

   assign md_gnt     = (gnt == GNT_MD);
   assign md_refused = bus.md_req && !md_gnt;

   assign bus.rf_we    = (gnt != GNT_NONE) && (waddr != REG_ZERO);
   assign bus.rf_waddr = waddr;
   assign bus.rf_wdata = wdata;
   assign bus.md_ack   = md_gnt;
   assign bus.dbg_ack  = (gnt == GNT_DBG);

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      if (!md_refused)                                 starve_cnt_d = '0;
      else if (starve_cnt_q != {CNT_W{1'b1}})          starve_cnt_d = starve_cnt_q + CNT_W'(1);
      unique case (state_q)
         RUN:     if (md_refused && (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1))) state_d = HOLD;
         HOLD:    if (md_gnt) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state_q      <= RUN;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign bus.pipe_hold = (state_q == HOLD);

   regfile_scoreboard u_sb (
      .clk_i     (clock_in),
      .rst_ni    (reset),
      .set_en_i  (bus.md_issue),
      .set_idx_i (bus.md_issue_rd),
      .clr_en_i  (md_gnt),
      .clr_idx_i (bus.md_addr),
      .rs_i      (bus.id_rs),
      .rt_i      (bus.id_rt),
      .stall_o   (bus.stall)
   );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: the driver pushes per-cycle expectations from a reference
// model; a negedge monitor pops and compares against the arbiter outputs.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   localparam int LIMIT = 4;

   typedef struct packed {
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        md_issue;
      logic [4:0]  md_issue_rd;
      logic        md_req;
      logic [4:0]  md_addr;
      logic [31:0] md_data;
      logic        dbg_req;
      logic [4:0]  dbg_addr;
      logic [31:0] dbg_data;
      logic [4:0]  id_rs;
      logic [4:0]  id_rt;
   } stim_t;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic        md_ack;
      logic        dbg_ack;
      logic        stall;
      logic        pipe_hold;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_write_arbiter_if bus ();

   regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clock_in (clk),
      .reset    (rst_n),
      .bus      (bus.slave)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t expq[$];

   // Reference state: which registers await an MD result, whether the pipe is
   // frozen, and how many consecutive cycles MD has been turned away.
   bit [31:0] pend;
   bit        hold;
   int        refused;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic apply(input stim_t s);
      bus.wb_we       = s.wb_we;
      bus.wb_addr     = s.wb_addr;
      bus.wb_data     = s.wb_data;
      bus.md_issue    = s.md_issue;
      bus.md_issue_rd = s.md_issue_rd;
      bus.md_req      = s.md_req;
      bus.md_addr     = s.md_addr;
      bus.md_data     = s.md_data;
      bus.dbg_req     = s.dbg_req;
      bus.dbg_addr    = s.dbg_addr;
      bus.dbg_data    = s.dbg_data;
      bus.id_rs       = s.id_rs;
      bus.id_rt       = s.id_rt;
   endtask

   task automatic model_reset();
      pend    = '0;
      hold    = 1'b0;
      refused = 0;
      expq.delete();
   endtask

   // One cycle: apply stimulus after the edge, predict this cycle's outputs,
   // then advance the reference state to what the next edge should produce.
   task automatic drive(input stim_t s, output gnt_e w);
      exp_t e;
      bit   md_turned_away;
      @(posedge clk);
      #1;
      apply(s);
      e = '0;
      if (!hold && s.wb_we) w = GNT_WB;
      else if (s.md_req)    w = GNT_MD;
      else if (s.dbg_req)   w = GNT_DBG;
      else                  w = GNT_NONE;
      case (w)
         GNT_WB:  begin e.rf_waddr = s.wb_addr;  e.rf_wdata = s.wb_data;  end
         GNT_MD:  begin e.rf_waddr = s.md_addr;  e.rf_wdata = s.md_data;  end
         GNT_DBG: begin e.rf_waddr = s.dbg_addr; e.rf_wdata = s.dbg_data; end
         default: ;
      endcase
      e.rf_we     = (w != GNT_NONE) && (e.rf_waddr != 5'd0);
      e.md_ack    = (w == GNT_MD);
      e.dbg_ack   = (w == GNT_DBG);
      e.stall     = (s.id_rs != 5'd0 && pend[s.id_rs]) || (s.id_rt != 5'd0 && pend[s.id_rt]);
      e.pipe_hold = hold;
      expq.push_back(e);

      if (w == GNT_MD) pend[s.md_addr] = 1'b0;
      if (s.md_issue && s.md_issue_rd != 5'd0) pend[s.md_issue_rd] = 1'b1;
      md_turned_away = s.md_req && (w != GNT_MD);
      if (!hold && md_turned_away && (refused + 1 == LIMIT)) hold = 1'b1;
      else if (hold && w == GNT_MD)                            hold = 1'b0;
      refused = md_turned_away ? refused + 1 : 0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("rf_we",     bus.rf_we,     e.rf_we);
            check("md_ack",    bus.md_ack,    e.md_ack);
            check("dbg_ack",   bus.dbg_ack,   e.dbg_ack);
            check("stall",     bus.stall,     e.stall);
            check("pipe_hold", bus.pipe_hold, e.pipe_hold);
            check("wb_in_hold", bus.pipe_hold & bus.wb_we, 1'b0);
            if (e.rf_we) begin
               check("rf_waddr", bus.rf_waddr, e.rf_waddr);
               check("rf_wdata", bus.rf_wdata, e.rf_wdata);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      stim_t s;
      gnt_e  w;
      int    seen;
      bit    md_act, dbg_act;

      model_reset();
      // Requests during reset must all be ignored.
      s = '0;
      s.wb_we = 1; s.wb_addr = 5; s.wb_data = 32'h55;
      s.md_req = 1; s.md_addr = 6; s.dbg_req = 1; s.dbg_addr = 7;
      s.md_issue = 1; s.md_issue_rd = 3; s.id_rs = 3;
      apply(s);
      #12;
      check("rst_rf_we", bus.rf_we, 1'b0);
      check("rst_md_ack", bus.md_ack, 1'b0);
      check("rst_dbg_ack", bus.dbg_ack, 1'b0);
      check("rst_stall", bus.stall, 1'b0);
      check("rst_pipe_hold", bus.pipe_hold, 1'b0);
      apply('0);
      #1 rst_n = 1'b1;

      // Contention: WB, then MD, then DBG.
      s = '0;
      s.wb_we = 1; s.wb_addr = 5; s.wb_data = 32'h11;
      s.md_req = 1; s.md_addr = 6; s.md_data = 32'h22;
      s.dbg_req = 1; s.dbg_addr = 7; s.dbg_data = 32'h33;
      for (int i = 0; i < 3; i++) begin
         drive(s, w);
         s.wb_we = 0;
         if (w == GNT_MD)  s.md_req = 0;
         if (w == GNT_DBG) s.dbg_req = 0;
      end

      // Scoreboard hazard on r8 across issue, retire and afterwards.
      s = '0; s.md_issue = 1; s.md_issue_rd = 8; drive(s, w);
      s = '0; s.id_rs = 8; drive(s, w);
      s = '0; s.id_rs = 8; s.md_req = 1; s.md_addr = 8; s.md_data = 32'h88; drive(s, w);
      s = '0; s.id_rs = 8; drive(s, w);
      s = '0; s.id_rt = 8; drive(s, w);

      // Starvation: WB hogs the port until the pipe is held.
      s = '0; s.md_req = 1; s.md_addr = 10; s.md_data = 32'hA0; s.wb_we = 1; s.wb_data = 32'hB0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         s.wb_addr = 5'(11 + i);
         drive(s, w);
         if (bus.pipe_hold === 1'b0 && s.wb_we) seen++;
         if (w == GNT_MD) break;
         s.wb_we = !hold;
      end
      check("starve_cycles", seen, LIMIT);
      s = '0; drive(s, w);

      // Register 0 handling.
      s = '0; s.md_issue = 1; s.md_issue_rd = 0; s.id_rs = 0; drive(s, w);
      s = '0; s.md_req = 1; s.md_addr = 0; s.md_data = 32'hDEAD; drive(s, w);
      s = '0; s.dbg_req = 1; s.dbg_addr = 0; s.dbg_data = 32'hBEEF; drive(s, w);
      s = '0; s.wb_we = 1; s.wb_addr = 0; s.wb_data = 32'h1; drive(s, w);

      // Same-cycle retire and re-issue of r9: set wins.
      s = '0; s.md_issue = 1; s.md_issue_rd = 9; drive(s, w);
      s = '0; s.md_issue = 1; s.md_issue_rd = 9; s.md_req = 1; s.md_addr = 9; s.md_data = 32'h99; drive(s, w);
      s = '0; s.id_rs = 9; drive(s, w);
      s = '0; s.md_req = 1; s.md_addr = 9; s.md_data = 32'h9A; drive(s, w);

      // Mid-operation reset with r3/r4 pending and the pipe held.
      s = '0; s.md_issue = 1; s.md_issue_rd = 3; drive(s, w);
      s = '0; s.md_issue = 1; s.md_issue_rd = 4; drive(s, w);
      s = '0; s.md_req = 1; s.md_addr = 12; s.md_data = 32'hC0; s.wb_we = 1; s.wb_addr = 13;
      for (int i = 0; i < 8 && !hold; i++) drive(s, w);
      s.wb_we = 0; s.id_rs = 3; s.id_rt = 4;
      drive(s, w);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_pipe_hold", bus.pipe_hold, 1'b0);
      check("midrst_stall", bus.stall, 1'b0);
      check("midrst_md_ack", bus.md_ack, 1'b0);
      check("midrst_rf_we", bus.rf_we, 1'b0);
      s = '0; s.id_rs = 3; s.id_rt = 4;
      apply(s);
      model_reset();
      #1 rst_n = 1'b1;
      s = '0; s.id_rs = 3; s.id_rt = 4;
      s.wb_we = 1; s.wb_addr = 13; s.wb_data = 32'hD1;
      s.md_req = 1; s.md_addr = 14; s.md_data = 32'hD2;
      s.dbg_req = 1; s.dbg_addr = 15; s.dbg_data = 32'hD3;
      for (int i = 0; i < 3; i++) begin
         drive(s, w);
         s.wb_we = 0;
         if (w == GNT_MD)  s.md_req = 0;
         if (w == GNT_DBG) s.dbg_req = 0;
      end

      // Randomized traffic honouring the request/hold protocol.
      md_act = 0; dbg_act = 0;
      s = '0;
      for (int i = 0; i < 400; i++) begin
         if (!md_act && $urandom_range(0, 2) == 0) begin
            md_act = 1; s.md_addr = 5'($urandom_range(0, 11)); s.md_data = $urandom;
         end
         if (!dbg_act && $urandom_range(0, 3) == 0) begin
            dbg_act = 1; s.dbg_addr = 5'($urandom_range(0, 11)); s.dbg_data = $urandom;
         end
         s.md_req      = md_act;
         s.dbg_req     = dbg_act;
         s.wb_we       = !hold && ($urandom_range(0, 3) != 0);
         s.wb_addr     = 5'($urandom_range(0, 11));
         s.wb_data     = $urandom;
         s.md_issue    = ($urandom_range(0, 3) == 0);
         s.md_issue_rd = 5'($urandom_range(0, 11));
         s.id_rs       = 5'($urandom_range(0, 11));
         s.id_rt       = 5'($urandom_range(0, 11));
         drive(s, w);
         if (w == GNT_MD)  md_act = 0;
         if (w == GNT_DBG) dbg_act = 0;
      end

      s = '0; drive(s, w);
      repeat (2) @(posedge clk);
      check("queue_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
